// File: rtl/event_normalizer.sv
// Quantises raw DVS events to graph coordinates and tracks the sliding time window.
// Latency: 2 cycles from raw_valid to out_event.valid; throughput 1 event/cycle.
// Backpressure: none; malformed or non-monotonic events are dropped and counted.
package graph_pkg;
    localparam int GRAPH_SIZE  = 64;
    localparam int TIME_WINDOW = 1024;
    localparam int GW          = $clog2(GRAPH_SIZE);

    typedef struct packed {
        logic          valid;
        logic [GW-1:0] x;
        logic [GW-1:0] y;
        logic [GW-1:0] t;
        logic          p;
    } event_type;
endpackage

module event_normalizer #(
    parameter int GRAPH_SIZE  = graph_pkg::GRAPH_SIZE,
    parameter int SENSOR_SIZE = 256,
    parameter int TIME_WINDOW = graph_pkg::TIME_WINDOW,
    parameter int TS_WIDTH    = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           raw_valid,
    input  logic [$clog2(SENSOR_SIZE):0]   raw_x,
    input  logic [$clog2(SENSOR_SIZE):0]   raw_y,
    input  logic [TS_WIDTH-1:0]            raw_t,
    input  logic                           raw_p,
    output graph_pkg::event_type           out_event,
    output logic                           reset_context,
    output logic [CNT_WIDTH-1:0]           drop_count
);
    localparam int SB       = $clog2(SENSOR_SIZE);
    localparam int GW       = $clog2(GRAPH_SIZE);
    localparam int XY_SHIFT = $clog2(SENSOR_SIZE / GRAPH_SIZE);
    localparam int T_SHIFT  = $clog2(TIME_WINDOW / GRAPH_SIZE);
    localparam logic [TS_WIDTH-1:0] WIN_MASK = TS_WIDTH'(TIME_WINDOW - 1);

    typedef enum logic {WAIT_FIRST, RUN} state_t;
    state_t state;

    logic                s1_valid;
    logic                s1_rng_err;
    logic                s1_p;
    logic [GW-1:0]       s1_x;
    logic [GW-1:0]       s1_y;
    logic [TS_WIDTH-1:0] s1_t;
    logic [TS_WIDTH-1:0] t0;

    // Raw coordinates are at most 2*SENSOR_SIZE-1, so the MSB alone flags out-of-range.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_rng_err <= 1'b0;
            s1_p       <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_t       <= '0;
        end else begin
            s1_valid   <= raw_valid;
            s1_rng_err <= raw_x[SB] | raw_y[SB];
            s1_p       <= raw_p;
            s1_x       <= raw_x[SB-1:XY_SHIFT];
            s1_y       <= raw_y[SB-1:XY_SHIFT];
            s1_t       <= raw_t;
        end
    end

    logic [TS_WIDTH-1:0] t_rel;
    logic [TS_WIDTH-1:0] t_off;
    logic                crossing;
    logic                drop;
    logic [GW-1:0]       t_q;

    assign t_rel    = s1_t - t0;
    assign t_off    = t_rel & WIN_MASK;
    assign crossing = |(t_rel & ~WIN_MASK);
    assign drop     = s1_rng_err || ((state == RUN) && (s1_t < t0));
    // Below the window t_rel == t_off, so one quantiser serves both cases.
    assign t_q      = t_off[T_SHIFT +: GW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_FIRST;
            t0            <= '0;
            out_event     <= '0;
            reset_context <= 1'b0;
            drop_count    <= '0;
        end else begin
            out_event.valid <= 1'b0;
            reset_context   <= 1'b0;
            if (s1_valid) begin
                if (drop) begin
                    if (drop_count != '1)
                        drop_count <= drop_count + 1'b1;
                end else begin
                    out_event.valid <= 1'b1;
                    out_event.x     <= s1_x;
                    out_event.y     <= s1_y;
                    out_event.p     <= s1_p;
                    if (state == WAIT_FIRST) begin
                        t0          <= s1_t;
                        out_event.t <= '0;
                        state       <= RUN;
                    end else begin
                        out_event.t <= t_q;
                        // Window-aligned rebase covers multi-window gaps in one step.
                        if (crossing) begin
                            t0            <= s1_t - t_off;
                            reset_context <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_event_normalizer.sv
// Directed bench for event_normalizer: vector table plus multi-cycle sequences.
module tb_event_normalizer;
    logic        clk = 1'b0;
    logic        reset;
    logic        raw_valid;
    logic [8:0]  raw_x;
    logic [8:0]  raw_y;
    logic [31:0] raw_t;
    logic        raw_p;
    graph_pkg::event_type out_event;
    logic        reset_context;
    logic [15:0] drop_count;
    graph_pkg::event_type sat_event;
    logic        sat_rc;
    logic [2:0]  sat_drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    event_normalizer dut (
        .clk(clk), .reset(reset), .raw_valid(raw_valid), .raw_x(raw_x), .raw_y(raw_y),
        .raw_t(raw_t), .raw_p(raw_p), .out_event(out_event),
        .reset_context(reset_context), .drop_count(drop_count)
    );

    event_normalizer #(.CNT_WIDTH(3)) dut_sat (
        .clk(clk), .reset(reset), .raw_valid(raw_valid), .raw_x(raw_x), .raw_y(raw_y),
        .raw_t(raw_t), .raw_p(raw_p), .out_event(sat_event),
        .reset_context(sat_rc), .drop_count(sat_drop)
    );

    typedef struct {
        int rst; int x; int y; int t; int p;
        int vld; int ex; int ey; int et; int erc; int edrop;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        raw_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input int x, input int y, input int t, input int p);
        raw_valid = 1'b1;
        raw_x = 9'(x);
        raw_y = 9'(y);
        raw_t = 32'(t);
        raw_p = 1'(p);
    endtask

    int bt[4];
    int bx[4];
    int bet[4];
    int brc[4];

    initial begin
        reset = 1'b1;
        raw_valid = 1'b0;
        raw_x = '0; raw_y = '0; raw_t = '0; raw_p = 1'b0;

        //          rst  x    y    t     p   vld ex  ey  et rc drop
        vecs[0]  = '{1, 100,   8, 5000, 1,  1, 25,  2,  0, 0, 0};
        vecs[1]  = '{0,   4,   4, 6023, 0,  1,  1,  1, 63, 0, 0};
        vecs[2]  = '{0, 255, 255, 6024, 1,  1, 63, 63,  0, 1, 0};
        vecs[3]  = '{1,   0,   0, 5000, 0,  1,  0,  0,  0, 0, 0};
        vecs[4]  = '{0,   8,  12, 8104, 1,  1,  2,  3,  2, 1, 0};
        vecs[5]  = '{0,   0,   0, 8071, 0,  0,  0,  0,  0, 0, 1};
        vecs[6]  = '{0, 256,   0, 9000, 0,  0,  0,  0,  0, 0, 2};
        vecs[7]  = '{0,   0, 256, 9000, 0,  0,  0,  0,  0, 0, 3};
        vecs[8]  = '{0,   1,   1, 8072, 1,  1,  0,  0,  0, 0, 3};
        vecs[9]  = '{0, 511,   0, 9000, 0,  0,  0,  0,  0, 0, 4};
        vecs[10] = '{0,  20,  40, 8152, 0,  1,  5, 10,  5, 0, 4};
        vecs[11] = '{1, 300,   0,  100, 0,  0,  0,  0,  0, 0, 1};
        vecs[12] = '{0,  12,   0,  200, 1,  1,  3,  0,  0, 0, 1};
        vecs[13] = '{0,   0,   0,  199, 0,  0,  0,  0,  0, 0, 2};
        vecs[14] = '{0,   0,   0, 2248, 0,  1,  0,  0,  0, 1, 2};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(out_event.valid), 0);
        chk("rst_fields", 32'(out_event), 0);
        chk("rst_rc", 32'(reset_context), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_sat_drop", 32'(sat_drop), 0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst != 0) do_reset();
            @(negedge clk);
            drive(vecs[i].x, vecs[i].y, vecs[i].t, vecs[i].p);
            @(negedge clk);
            raw_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(out_event.valid), 32'(vecs[i].vld));
            if (vecs[i].vld != 0) begin
                chk($sformatf("v%0d_x", i), 32'(out_event.x), 32'(vecs[i].ex));
                chk($sformatf("v%0d_y", i), 32'(out_event.y), 32'(vecs[i].ey));
                chk($sformatf("v%0d_t", i), 32'(out_event.t), 32'(vecs[i].et));
                chk($sformatf("v%0d_p", i), 32'(out_event.p), 32'(vecs[i].p));
            end
            chk($sformatf("v%0d_rc", i), 32'(reset_context), 32'(vecs[i].erc));
            chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vecs[i].edrop));
        end

        // Back-to-back events, third crosses the window, fourth uses the new t0
        bt  = '{1000, 1100, 2030, 2100};
        bx  = '{0, 4, 8, 12};
        bet = '{0, 6, 0, 4};
        brc = '{0, 0, 1, 0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("b2b%0d_valid", c - 2), 32'(out_event.valid), 1);
                chk($sformatf("b2b%0d_x", c - 2), 32'(out_event.x), 32'(bx[c-2] / 4));
                chk($sformatf("b2b%0d_t", c - 2), 32'(out_event.t), 32'(bet[c-2]));
                chk($sformatf("b2b%0d_rc", c - 2), 32'(reset_context), 32'(brc[c-2]));
            end
            if (c < 4) drive(bx[c], 16, bt[c], c % 2);
            else raw_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_tail_valid", 32'(out_event.valid), 0);
        chk("b2b_tail_rc", 32'(reset_context), 0);

        // Reset with events in flight
        @(negedge clk);
        drive(4, 4, 3000, 1);
        @(negedge clk);
        drive(8, 8, 3001, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        raw_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("flush%0d_valid", c), 32'(out_event.valid), 0);
            chk($sformatf("flush%0d_rc", c), 32'(reset_context), 0);
            @(negedge clk);
        end
        drive(40, 80, 7777, 1);
        @(negedge clk);
        raw_valid = 1'b0;
        @(negedge clk);
        chk("restart_valid", 32'(out_event.valid), 1);
        chk("restart_x", 32'(out_event.x), 10);
        chk("restart_y", 32'(out_event.y), 20);
        chk("restart_t", 32'(out_event.t), 0);
        chk("restart_rc", 32'(reset_context), 0);
        chk("restart_drop", 32'(drop_count), 0);

        // Drop counter saturation on the narrow-counter instance
        for (int c = 0; c < 10; c++) begin
            drive(256, 0, 9000, 0);
            @(negedge clk);
            if (c >= 2) chk($sformatf("sat%0d_valid", c), 32'(out_event.valid), 0);
        end
        raw_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_count_10", 32'(drop_count), 10);
        chk("sat_drop_stuck", 32'(sat_drop), 7);
        chk("sat_no_valid", 32'(sat_event.valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
